// File: rtl/int_arbiter_if.sv
// CPU-side bus of the interrupt controller: the intr/inta handshake and the
// word-addressed register port.
interface int_arbiter_if;
  logic        intr;
  logic        inta;
  logic [2:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    input  intr,
    input  rdata,
    output inta,
    output addr,
    output we,
    output wdata
  );

  modport slave (
    output intr,
    output rdata,
    input  inta,
    input  addr,
    input  we,
    input  wdata
  );
endinterface

// File: rtl/int_arbiter.sv
// Programmable interrupt controller: latches edge/level requests, masks them,
// and hands one fixed-priority winner to the CPU per intr/inta/EOI round.
module int_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [N_SRC-1:0] irq_in,
  int_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_mode;
  logic             r_intr;
  logic             r_vecValid;
  logic [2:0]       r_vecId;

  logic [N_SRC-1:0] w_active;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_ackClr;
  logic [N_SRC-1:0] w_pendNext;
  logic [2:0]       w_winId;
  logic             w_req;
  logic             w_ack;
  logic             w_eoi;
  logic             w_pendWr;
  logic             w_maskWr;
  logic             w_modeWr;

  assign w_active = r_pend & r_mask;
  assign w_req    = |w_active;
  assign w_pendWr = bus.we && (bus.addr == 3'd0);
  assign w_maskWr = bus.we && (bus.addr == 3'd1);
  assign w_modeWr = bus.we && (bus.addr == 3'd2);
  assign w_ack    = (r_state == REQ) && bus.inta && w_req;
  assign w_eoi    = (r_state == SERVICE) && bus.we && (bus.addr == 3'd4);
  assign w_w1c    = w_pendWr ? bus.wdata[N_SRC-1:0] : '0;

  // Scan from the top so the lowest set index is the last to overwrite.
  always_comb begin
    w_winId = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) w_winId = 3'(i);
    end
  end

  always_comb begin
    w_ackClr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_ackClr[i] = w_ack && (w_winId == 3'(i));
    end
  end

  // A fresh edge outranks both the W1C clear and the acknowledge clear.
  assign w_pendNext = (r_mode & ((irq_in & ~r_prev) | (r_pend & ~w_w1c & ~w_ackClr)))
                    | (~r_mode & irq_in);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_req) w_stateNext = REQ;
      REQ: begin
        if (w_ack)       w_stateNext = SERVICE;
        else if (!w_req) w_stateNext = IDLE;
      end
      SERVICE: if (w_eoi) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state <= IDLE;
      r_intr  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_intr  <= (w_stateNext == REQ);
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_prev <= '0;
      r_pend <= '0;
      r_mask <= '0;
      r_mode <= '0;
    end else begin
      r_prev <= irq_in;
      r_pend <= w_pendNext;
      if (w_maskWr) r_mask <= bus.wdata[N_SRC-1:0];
      if (w_modeWr) r_mode <= bus.wdata[N_SRC-1:0];
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_vecValid <= 1'b0;
      r_vecId    <= 3'd0;
    end else if (w_ack) begin
      r_vecValid <= 1'b1;
      r_vecId    <= w_winId;
    end else if (w_eoi) begin
      r_vecValid <= 1'b0;
      r_vecId    <= 3'd0;
    end
  end

  assign bus.intr = r_intr;

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      3'd0:    bus.rdata = {{(32-N_SRC){1'b0}}, r_pend};
      3'd1:    bus.rdata = {{(32-N_SRC){1'b0}}, r_mask};
      3'd2:    bus.rdata = {{(32-N_SRC){1'b0}}, r_mode};
      3'd3:    bus.rdata = {r_vecValid, 28'd0, r_vecId};
      default: bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: a rule-level reference model checked every
// cycle, plus hand-computed literal checks along the scenario.
module tb_int_arbiter;

  logic       Clk = 1'b0;
  logic       Clrn = 1'b0;
  logic [3:0] irq_in = 4'd0;

  int_arbiter_if bus();

  int_arbiter #(.N_SRC(4)) dut (
    .Clk    (Clk),
    .Clrn   (Clrn),
    .irq_in (irq_in),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  // Reference model state
  logic [3:0] mPend = 4'd0;
  logic [3:0] mMask = 4'd0;
  logic [3:0] mMode = 4'd0;
  logic [3:0] mPrev = 4'd0;
  int         mState = 0;
  logic       mIntr = 1'b0;
  logic       mValid = 1'b0;
  int         mId = 0;

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    case (a)
      3'd0: return {28'd0, mPend};
      3'd1: return {28'd0, mMask};
      3'd2: return {28'd0, mMode};
      3'd3: return {mValid, 28'd0, 3'(mId)};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      mPend = 0; mMask = 0; mMode = 0; mPrev = 0;
      mState = 0; mIntr = 0; mValid = 0; mId = 0;
    end else begin
      int  win;
      bit  anyReq;
      bit  granted;
      bit  eoi;
      logic [3:0] newPend;
      win = -1;
      for (int i = 0; i < 4; i++)
        if (win < 0 && mPend[i] && mMask[i]) win = i;
      anyReq  = (win >= 0);
      granted = (mState == 1) && bus.inta && anyReq;
      eoi     = (mState == 2) && bus.we && (bus.addr == 3'd4);
      for (int i = 0; i < 4; i++) begin
        if (!mMode[i]) newPend[i] = irq_in[i];
        else if (irq_in[i] && !mPrev[i]) newPend[i] = 1'b1;
        else if (bus.we && bus.addr == 3'd0 && bus.wdata[i]) newPend[i] = 1'b0;
        else if (granted && win == i) newPend[i] = 1'b0;
        else newPend[i] = mPend[i];
      end
      if (granted) begin mValid = 1; mId = win; end
      else if (eoi) begin mValid = 0; mId = 0; end
      if (mState == 0 && anyReq) mState = 1;
      else if (mState == 1 && granted) mState = 2;
      else if (mState == 1 && !anyReq) mState = 0;
      else if (eoi) mState = 0;
      mIntr = (mState == 1);
      if (bus.we && bus.addr == 3'd1) mMask = bus.wdata[3:0];
      if (bus.we && bus.addr == 3'd2) mMode = bus.wdata[3:0];
      mPend = newPend;
      mPrev = irq_in;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge Clk) begin
    vectors++;
    if (bus.intr !== mIntr) begin
      miscompares++;
      $display("[TB] FAIL model_intr @%0t: got %b, expected %b", $time, bus.intr, mIntr);
    end
    vectors++;
    if (bus.rdata !== modelRead(bus.addr)) begin
      miscompares++;
      $display("[TB] FAIL model_rdata addr %0d @%0t: got %h, expected %h",
               bus.addr, $time, bus.rdata, modelRead(bus.addr));
    end
  end

  task automatic applyStimulus(input logic [3:0] irq, input logic ack, input logic wr,
                               input logic [2:0] a, input logic [31:0] d);
    irq_in    = irq;
    bus.inta  = ack;
    bus.we    = wr;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge Clk);
    #2;
    bus.inta  = 1'b0;
    bus.we    = 1'b0;
    bus.wdata = 32'd0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkReg(input string name, input logic [2:0] a, input logic [31:0] expected);
    bus.addr = a;
    #1;
    checkOutput(name, bus.rdata, expected);
  endtask

  initial begin
    bus.inta  = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 3'd0;
    bus.wdata = 32'd0;
    repeat (2) @(posedge Clk);
    #2;
    Clrn = 1'b1;
    #1;
    checkOutput("reset_intr", {31'd0, bus.intr}, 32'd0);
    for (int a = 0; a < 8; a++) checkReg("reset_rdata", 3'(a), 32'd0);

    // Single edge on source 2
    applyStimulus(4'b0000, 0, 1, 3'd1, 32'hF);
    applyStimulus(4'b0000, 0, 1, 3'd2, 32'hF);
    applyStimulus(4'b0100, 0, 0, 3'd0, 0);
    checkOutput("edge_intr_1edge", {31'd0, bus.intr}, 32'd0);
    checkReg("edge_pend_set", 3'd0, 32'h4);
    applyStimulus(4'b0000, 0, 0, 3'd0, 0);
    checkOutput("edge_intr_2edges", {31'd0, bus.intr}, 32'd1);
    applyStimulus(4'b0000, 1, 0, 3'd0, 0);
    checkOutput("ack_intr_low", {31'd0, bus.intr}, 32'd0);
    checkReg("ack_vec", 3'd3, 32'h8000_0002);
    checkReg("ack_pend_clr", 3'd0, 32'h0);
    applyStimulus(4'b0000, 0, 1, 3'd4, 32'h1234);
    checkReg("eoi_vec", 3'd3, 32'h0);

    // Two simultaneous edges: priority then re-request after EOI
    applyStimulus(4'b1010, 0, 0, 3'd0, 0);
    applyStimulus(4'b0000, 0, 0, 3'd0, 0);
    checkOutput("dual_intr", {31'd0, bus.intr}, 32'd1);
    applyStimulus(4'b0000, 1, 0, 3'd0, 0);
    checkReg("dual_vec1", 3'd3, 32'h8000_0001);
    checkReg("dual_pend", 3'd0, 32'h8);
    applyStimulus(4'b0000, 0, 1, 3'd4, 0);
    checkOutput("dual_eoi_intr", {31'd0, bus.intr}, 32'd0);
    applyStimulus(4'b0000, 0, 0, 3'd0, 0);
    checkOutput("dual_reassert", {31'd0, bus.intr}, 32'd1);
    applyStimulus(4'b0000, 1, 0, 3'd0, 0);
    checkReg("dual_vec3", 3'd3, 32'h8000_0003);
    applyStimulus(4'b0000, 0, 1, 3'd4, 0);

    // Level source 0 drops before acknowledge
    applyStimulus(4'b0000, 0, 1, 3'd2, 32'h0);
    applyStimulus(4'b0000, 0, 1, 3'd1, 32'h1);
    applyStimulus(4'b0001, 0, 0, 3'd0, 0);
    applyStimulus(4'b0001, 0, 0, 3'd0, 0);
    checkOutput("level_intr", {31'd0, bus.intr}, 32'd1);
    applyStimulus(4'b0000, 0, 0, 3'd0, 0);
    applyStimulus(4'b0000, 0, 0, 3'd0, 0);
    checkOutput("level_drop_intr", {31'd0, bus.intr}, 32'd0);
    checkReg("level_drop_vec", 3'd3, 32'h0);

    // Request arriving during service stays pending
    applyStimulus(4'b0000, 0, 1, 3'd2, 32'hF);
    applyStimulus(4'b0000, 0, 1, 3'd1, 32'hF);
    applyStimulus(4'b0100, 0, 0, 3'd0, 0);
    applyStimulus(4'b0000, 0, 0, 3'd0, 0);
    applyStimulus(4'b0000, 1, 0, 3'd0, 0);
    checkReg("svc_vec2", 3'd3, 32'h8000_0002);
    applyStimulus(4'b0001, 1, 0, 3'd0, 0);
    applyStimulus(4'b0000, 0, 0, 3'd0, 0);
    checkOutput("svc_intr_held", {31'd0, bus.intr}, 32'd0);
    checkReg("svc_pend0", 3'd0, 32'h1);
    checkReg("svc_vec_kept", 3'd3, 32'h8000_0002);
    applyStimulus(4'b0000, 0, 1, 3'd4, 0);
    applyStimulus(4'b0000, 0, 0, 3'd0, 0);
    checkOutput("svc_post_eoi_intr", {31'd0, bus.intr}, 32'd1);
    applyStimulus(4'b0000, 1, 0, 3'd0, 0);
    checkReg("svc_vec0", 3'd3, 32'h8000_0000);
    applyStimulus(4'b0000, 0, 1, 3'd4, 0);

    // Masked pending, W1C racing a new edge, then unmask
    applyStimulus(4'b0000, 0, 1, 3'd1, 32'h0);
    applyStimulus(4'b0010, 0, 0, 3'd0, 0);
    applyStimulus(4'b0000, 0, 0, 3'd0, 0);
    checkReg("mask_pend", 3'd0, 32'h2);
    checkOutput("mask_intr", {31'd0, bus.intr}, 32'd0);
    applyStimulus(4'b0010, 0, 1, 3'd0, 32'h2);
    applyStimulus(4'b0000, 0, 0, 3'd0, 0);
    checkReg("w1c_race_pend", 3'd0, 32'h2);
    applyStimulus(4'b0000, 0, 1, 3'd0, 32'h2);
    checkReg("w1c_clear_pend", 3'd0, 32'h0);
    applyStimulus(4'b0010, 0, 0, 3'd0, 0);
    applyStimulus(4'b0000, 0, 1, 3'd1, 32'h2);
    checkOutput("unmask_intr_wait", {31'd0, bus.intr}, 32'd0);
    applyStimulus(4'b0000, 0, 0, 3'd0, 0);
    checkOutput("unmask_intr", {31'd0, bus.intr}, 32'd1);

    // Asynchronous reset while in REQ
    @(posedge Clk);
    #1;
    Clrn = 1'b0;
    #1;
    checkOutput("areset_intr", {31'd0, bus.intr}, 32'd0);
    checkReg("areset_mask", 3'd1, 32'h0);
    checkReg("areset_pend", 3'd0, 32'h0);
    checkReg("areset_vec", 3'd3, 32'h0);
    @(posedge Clk);
    #2;
    Clrn = 1'b1;
    applyStimulus(4'b0000, 0, 0, 3'd2, 0);
    checkReg("post_reset_mode", 3'd2, 32'h0);
    checkOutput("post_reset_intr", {31'd0, bus.intr}, 32'd0);

    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
